cv32e40x_div: RTL
=================

CV32E40X_DIV -- requirements
Module: cv32e40x_div

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 valid_i  input  1  operation request from the issuing stage.
REQ-006 operator_i  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 op_a_i  input  32  dividend.
REQ-008 op_b_i  input  32  divisor.
REQ-009 result_o  output  32  quotient (DIV/DIVU) or remainder (REM/REMU); defined only while valid_o=1.
REQ-010 ready_o  output  1  divider can accept a new operation.
REQ-011 valid_o  output  1  result_o holds a completed result.
REQ-012 ready_i  input  1  downstream consumes the result.

Function
REQ-013 FSM states SHALL be IDLE, DIVIDE and DONE.
- ready_o=1 only in IDLE.
- valid_o=1 only in DONE.
REQ-014 An operation SHALL be accepted on a cycle with valid_i=1 in IDLE.
- On acceptance: operator_i, operand signs, |op_a_i| and |op_b_i| are latched.
- Inputs need not stay stable after acceptance.
REQ-015 Signedness:
- DIV and REM treat operands as two's complement.
- DIVU and REMU treat operands as unsigned; no negation is applied.
REQ-016 Normal path: IDLE -> DIVIDE with a 5-bit iteration counter loaded to 31.
REQ-017 DIVIDE SHALL perform one restoring radix-2 step per cycle.
- Shift the 33-bit partial remainder left, bringing in the next dividend MSB.
- Subtract the divisor.
- If the difference is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-018 DIVIDE SHALL last exactly 32 cycles; when the counter equals 0, go to DONE.
- With acceptance in cycle N, valid_o first asserts in cycle N+33.
REQ-019 Sign correction SHALL be applied combinationally in DONE.
- Quotient is negated for DIV when the operand signs differ.
- Remainder is negated for REM when the dividend is negative.
REQ-020 Divide by zero (op_b_i=0) SHALL bypass DIVIDE: IDLE -> DONE, valid_o in cycle N+1.
- Quotient = 0xFFFFFFFF for both DIV and DIVU.
- Remainder = op_a_i unchanged for both REM and REMU.
REQ-021 Signed overflow (DIV/REM, op_a_i=0x80000000, op_b_i=0xFFFFFFFF) SHALL bypass DIVIDE: IDLE -> DONE, valid_o in cycle N+1.
- Quotient = 0x80000000.
- Remainder = 0x00000000.
REQ-022 In DONE, valid_o and result_o SHALL remain stable while ready_i=0.
REQ-023 DONE with ready_i=1 SHALL return to IDLE in the next cycle.
- No new operation is accepted in the same cycle.
- Minimum issue interval: 34 cycles normal, 2 cycles bypass.
REQ-024 valid_i in DIVIDE or DONE SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-025 Operator or operand changes after acceptance SHALL NOT affect the result.
REQ-026 Arithmetic width: partial remainder 33 bits; quotient and divisor registers 32 bits.
- 0x80000000 magnitude is handled unsigned without overflow.

Reset
REQ-027 When rst=1 at a clock edge, the FSM SHALL enter IDLE and all datapath registers SHALL clear to 0.
- Next-cycle outputs: ready_o=1, valid_o=0, result_o=0.
REQ-028 Reset asserted mid-operation (DIVIDE or DONE) SHALL abandon the operation.
- No valid_o pulse for it afterwards.
REQ-029 After reset deassertion, an operation SHALL be acceptable in the first cycle.

Verification
REQ-030 DIVU 100/7, accepted in cycle N -> valid_o first at N+33, result_o=14; REMU same operands -> 2.
REQ-031 DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-032 DIVU 5/0 -> 0xFFFFFFFF at N+1; REM 0x80000000/0 -> 0x80000000 at N+1.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1; REM same operands -> 0x00000000.
REQ-034 Backpressure: DIVU 100/7 with ready_i=0 for 5 cycles after valid_o.
- valid_o=1 and result_o=14 held for those 5 cycles.
- IDLE follows the ready_i=1 cycle; ready_o=1 one cycle later.
REQ-035 Reset mid-operation: rst=1 in cycle N+10 of a DIV -> ready_o=1, valid_o=0 in cycle N+11.
- No valid_o thereafter.
- A new DIVU 9/3 accepted immediately returns 3.

Source files
------------

// File: rtl/cv32e40x_div_if.sv
// cv32e40x_div_if: request/result handshake between the issuing stage and the divider.
interface cv32e40x_div_if;
    logic        valid_i;
    logic [1:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    modport master (
        output valid_i, operator_i, op_a_i, op_b_i, ready_i,
        input  result_o, ready_o, valid_o
    );
    modport slave (
        input  valid_i, operator_i, op_a_i, op_b_i, ready_i,
        output result_o, ready_o, valid_o
    );
endinterface

// File: rtl/cv32e40x_div.sv
// cv32e40x_div: 32-bit restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
module cv32e40x_div (
    input  logic             clk,
    input  logic             rst,
    cv32e40x_div_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
    state_t      state, state_nxt;
    logic [1:0]  op;
    logic        neg_q, neg_r;
    logic [4:0]  cnt;
    logic [31:0] rem, quo, dvs;
    logic        is_signed, sign_a, sign_b, div_zero, ovf, bypass, accept;
    logic [31:0] abs_a, abs_b, res_q, res_r;
    logic [32:0] rem_sh, diff;
    assign is_signed = ~bus.operator_i[0];
    assign sign_a    = is_signed & bus.op_a_i[31];
    assign sign_b    = is_signed & bus.op_b_i[31];
    assign abs_a     = sign_a ? -bus.op_a_i : bus.op_a_i;
    assign abs_b     = sign_b ? -bus.op_b_i : bus.op_b_i;
    assign div_zero  = bus.op_b_i == 32'h0;
    assign ovf       = is_signed & (bus.op_a_i == 32'h8000_0000) & (bus.op_b_i == 32'hFFFF_FFFF);
    assign bypass    = div_zero | ovf;
    assign accept    = (state == IDLE) & bus.valid_i;
    // 33-bit shifted partial remainder; the sign of the difference decides the quotient bit
    assign rem_sh    = {rem, quo[31]};
    assign diff      = rem_sh - {1'b0, dvs};
    assign res_q     = neg_q ? -quo : quo;
    assign res_r     = neg_r ? -rem : rem;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt   = state;
        bus.ready_o = 1'b0;
        bus.valid_o = 1'b0;
        state_nxt   = state == IDLE   ? (bus.valid_i ? (bypass ? DONE : DIVIDE) : IDLE) :
                      state == DIVIDE ? (cnt == 5'd0 ? DONE : DIVIDE) :
                                        (bus.ready_i ? IDLE : DONE);
        bus.ready_o = state == IDLE;
        bus.valid_o = state == DONE;
    end
    // Bypass cases preload the final result and clear the sign flags so DONE passes it through
    always_ff @(posedge clk) begin
        if (rst) begin
            op    <= 2'b00;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= 5'd0;
            rem   <= 32'h0;
            quo   <= 32'h0;
            dvs   <= 32'h0;
        end else if (accept) begin
            op    <= bus.operator_i;
            neg_q <= ~bypass & (sign_a ^ sign_b);
            neg_r <= ~bypass & sign_a;
            cnt   <= 5'd31;
            dvs   <= abs_b;
            rem   <= div_zero ? bus.op_a_i : 32'h0;
            quo   <= div_zero ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : abs_a;
        end else if (state == DIVIDE) begin
            cnt   <= cnt - 5'd1;
            rem   <= diff[32] ? rem_sh[31:0] : diff[31:0];
            quo   <= {quo[30:0], ~diff[32]};
        end
    end
    assign bus.result_o = op[1] ? res_r : res_q;
endmodule
